// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester beat counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_beats
`endif
);

  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  if (NUM_REQ < 2)   begin : g_chk_req   $error("NUM_REQ must be >= 2");   end
  if (MAX_BURST < 1) begin : g_chk_burst $error("MAX_BURST must be >= 1"); end
  if (CNT_WIDTH < 1) begin : g_chk_cnt   $error("CNT_WIDTH must be >= 1"); end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or above rr_q, wrapping.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_q) + k) % NUM_REQ;
      if (!pick_found && req_valid[ID_W'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    beat_d       = beat_q;
    req_ready    = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        req_ready[owner_q] = !fifo_full;
        // A write during reset would be lost by the FIFO's own reset.
        if (req_valid[owner_q] && !fifo_full && !rst) begin
          fifo_w_en    = 1'b1;
          fifo_data_in = data_arr[owner_q];
          beat_d       = beat_q + 1'b1;
          if (req_last[owner_q] || beat_q == BEAT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            rr_d    = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = owner_q;
  assign busy     = (state_q == BURST);

`ifdef FIFO_ARB_STATS_EN
  // Saturating beat counters; clear wins over a same-cycle beat.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
        cnt_q <= '0;
      end else if (fifo_w_en && owner_q == ID_W'(i) && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign stat_beats[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one FIFO write port (w_en/data_in/full) among NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- Grants are burst-locked: the owner keeps the port until it signals last, or until MAX_BURST beats have been written.
- Sits directly in front of the team's FIFO; its outputs drive the FIFO write port and it consumes the FIFO full flag.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- DATA_WIDTH, 8, data word width; must match the FIFO.
- MAX_BURST, 8, maximum beats per grant before forced re-arbitration; must be >= 1.
- CNT_WIDTH, 16, width of each statistics counter (optional feature only).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester valid.
- req_last  in  NUM_REQ  per-requester last-beat-of-burst flag; qualified by valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester ready; one-hot or zero.
- fifo_full  in  1  full flag from the FIFO.
- fifo_w_en  out  1  FIFO write enable.
- fifo_data_in  out  DATA_WIDTH  FIFO write data.
- grant_id  out  $clog2(NUM_REQ)  index of the current owner; valid while busy=1.
- busy  out  1  high in state BURST.

Behaviour:
- Reset values (rst sampled high at a rising edge):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - Therefore busy=0, grant_id=0, req_ready=0, fifo_w_en=0.
  - fifo_data_in is driven as 0 when fifo_w_en=0.
- State IDLE:
  - If any req_valid is set, select the first valid requester searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Register that index as owner, clear beat_cnt, and go to BURST.
  - No beat is written in IDLE, so arbitration costs exactly one cycle.
- State BURST, combinational outputs:
  - req_ready[owner] = !fifo_full; all other ready bits are 0.
  - fifo_w_en = req_valid[owner] & !fifo_full.
  - fifo_data_in = req_data[owner] when fifo_w_en=1, else 0.
- Beat accounting in BURST:
  - A beat is a cycle with fifo_w_en=1.
  - Each beat increments beat_cnt.
  - End of burst is a beat where req_last[owner]=1, or where beat_cnt==MAX_BURST-1.
  - On end of burst: state goes to IDLE and rr_ptr becomes (owner+1) mod NUM_REQ, so the just-served requester has lowest priority next.
- Boundary conditions:
  - fifo_full=1: no beat. beat_cnt and state hold, and the owner keeps the grant. Nothing may ever be written while full.
  - Owner drops valid mid-burst: the grant is held indefinitely. No timeout; the producer is required to complete its burst.
  - Non-owner valid during BURST: ignored; that requester's ready stays 0.
  - req_last on a non-beat cycle (valid=0 or full=1): no effect.
  - MAX_BURST=1: every grant is exactly one beat.
  - Single active requester: it is re-granted after one IDLE bubble; rr_ptr rotation must not block it.
  - Reset mid-burst: state returns to IDLE on the same edge and the partial burst is abandoned. No write occurs in the cycle rst is high, and fifo_w_en is forced to 0 while rst=1.
  - beat_cnt width is $clog2(MAX_BURST+1) and it never wraps.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds input stat_clr (1 bit) and output stat_beats (NUM_REQ*CNT_WIDTH). Requester i's count occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
  - Each counter increments on every beat written by that requester and saturates at all-ones.
  - Counters reset to 0 on rst, and on stat_clr. stat_clr has priority over a same-cycle increment.
- Undefined: neither port exists and no counter logic is built. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset then idle: rst high 2 cycles, all valid=0 -> busy=0, grant_id=0, req_ready=0, fifo_w_en=0 on every cycle.
- Round-robin: req0-3 all valid, each 1-beat burst (last=1), data 8'hA0+i -> FIFO receives A0,A1,A2,A3,A0..., with one idle cycle between beats; grant_id sequence 0,1,2,3,0.
- Burst lock and MAX_BURST: req1 valid with last=0, req2 valid, MAX_BURST=8 -> exactly 8 consecutive beats from req1, then IDLE, then grant_id=2.
- Backpressure: owner=0 mid-burst (beat_cnt=3), fifo_full high 5 cycles -> fifo_w_en=0 and req_ready=0 for those 5 cycles. beat_cnt holds at 3. After full drops, writes resume with no lost or duplicated word.
- Reset mid-burst: rst asserted on beat 2 of a req3 burst -> no write on that edge; next cycle busy=0 and rr_ptr=0; with req0 and req3 both valid, req0 is granted first.
- Stats (FIFO_ARB_STATS_EN): 3 beats from req0 and 5 from req2 -> stat_beats slots read 3,0,5,0. stat_clr=1 for 1 cycle -> all 0. With CNT_WIDTH=2 and 5 beats from req1, its slot saturates at 3.
